// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - register map, VECTOR field layout and priority helper for intc
package intc_pkg;

  localparam int NSRC_MAX = 8;

  typedef enum logic [3:0] {
    INTC_RAW     = 4'h0,
    INTC_PENDING = 4'h1,
    INTC_ENABLE  = 4'h2,
    INTC_MODE    = 4'h3,
    INTC_ROUTE   = 4'h4,
    INTC_VECTOR  = 4'h5,
    INTC_SUMMARY = 4'h6,
    INTC_SWSET   = 4'h7
  } intc_addr_e;

  localparam int VEC_VALID_BIT = 7;
  localparam int VEC_IDX_LSB   = 0;
  localparam int VEC_IDX_W     = 3;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [VEC_IDX_W-1:0] lowest_set(input logic [NSRC_MAX-1:0] v);
    lowest_set = '0;
    for (int i = NSRC_MAX - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = VEC_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/intc_sync_edge.sv
// rtl/intc_sync_edge.sv - 2-flop synchroniser and rising-edge detector for one source
module intc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic s_o,
  output logic rise_o
);

  logic meta_q, s_q, s_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      meta_q  <= src_i;
      s_q     <= meta_q;
      s_dly_q <= s_q;
    end
  end

  assign s_o    = s_q;
  assign rise_o = s_q & ~s_dly_q;

endmodule

// File: rtl/intc.sv
// rtl/intc.sv - podule-bus interrupt controller with per-source enable/mode/route
// Optional software trigger register built when INTC_SWTRIG_EN is defined.
module intc
  import intc_pkg::*;
#(
  parameter int         NSRC           = 5,
  parameter logic [7:0] EDGE_DEFAULT   = 8'h00,
  parameter logic [7:0] FIQ_DEFAULT    = 8'h10,
  parameter logic [7:0] ENABLE_DEFAULT = 8'h1F
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  output logic            fiq,
  inout  wire  [7:0]      D,
  input  logic [13:0]     A,
  input  logic            cs,
  input  logic            re,
  input  logic            we
);

  logic [NSRC-1:0] s, rise, pending, irq_vec, fiq_vec;
  logic [NSRC-1:0] enable_q, enable_d, mode_q, mode_d, route_q, route_d;
  logic [NSRC-1:0] latched_q, latched_d, w1c, mode_fall, wdata;
  logic            wr_q, wr_pulse, irq_q, fiq_q;
  logic [3:0]      addr;
  logic [7:0]      rdata, vector;
  logic            unused_bus;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    intc_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .src_i  (src[gi]),
      .s_o    (s[gi]),
      .rise_o (rise[gi])
    );
  end

  assign addr       = A[3:0];
  assign wdata      = D[NSRC-1:0];
  assign wr_pulse   = cs && we && !wr_q;
  assign unused_bus = ^{A[13:4], D};

  assign w1c       = (wr_pulse && addr == INTC_PENDING) ? wdata : '0;
  assign mode_fall = (wr_pulse && addr == INTC_MODE) ? (mode_q & ~wdata) : '0;

  // Set beats a same-cycle W1C; edge->level transitions drop the latch.
`ifdef INTC_SWTRIG_EN
  logic [NSRC-1:0] swset;
  assign swset     = (wr_pulse && addr == INTC_SWSET) ? wdata : '0;
  assign latched_d = (((latched_q & ~w1c) | (rise & mode_q)) & ~mode_fall) | swset;
  assign pending   = latched_q | (~mode_q & s);
`else
  assign latched_d = ((latched_q & ~w1c) | rise) & mode_q & ~mode_fall;
  assign pending   = (mode_q & latched_q) | (~mode_q & s);
`endif

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    route_d  = route_q;
    if (wr_pulse) begin
      case (addr)
        INTC_ENABLE: enable_d = wdata;
        INTC_MODE:   mode_d   = wdata;
        INTC_ROUTE:  route_d  = wdata;
        default:     ;
      endcase
    end
  end

  assign irq_vec = pending & enable_q & ~route_q;
  assign fiq_vec = pending & enable_q & route_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= 1'b0;
      enable_q  <= ENABLE_DEFAULT[NSRC-1:0];
      mode_q    <= EDGE_DEFAULT[NSRC-1:0];
      route_q   <= FIQ_DEFAULT[NSRC-1:0];
      latched_q <= '0;
      irq_q     <= 1'b0;
      fiq_q     <= 1'b0;
    end else begin
      wr_q      <= cs && we;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      route_q   <= route_d;
      latched_q <= latched_d;
      irq_q     <= |irq_vec;
      fiq_q     <= |fiq_vec;
    end
  end

  assign irq = irq_q;
  assign fiq = fiq_q;

  always_comb begin
    vector = '0;
    vector[VEC_VALID_BIT] = |irq_vec;
    vector[VEC_IDX_LSB +: VEC_IDX_W] = lowest_set(NSRC_MAX'(irq_vec));
  end

  always_comb begin
    rdata = '0;
    case (addr)
      INTC_RAW:     rdata = NSRC_MAX'(s);
      INTC_PENDING: rdata = NSRC_MAX'(pending);
      INTC_ENABLE:  rdata = NSRC_MAX'(enable_q);
      INTC_MODE:    rdata = NSRC_MAX'(mode_q);
      INTC_ROUTE:   rdata = NSRC_MAX'(route_q);
      INTC_VECTOR:  rdata = vector;
      INTC_SUMMARY: rdata = {6'b0, fiq_q, irq_q};
      default:      rdata = '0;
    endcase
  end

  assign D = (cs && re) ? rdata : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_intc.sv
// tb/tb_intc.sv - directed scoreboard bench for intc
module tb_intc;

  logic        clk = 1'b0;
  logic        rst, cs, re, we, drv, irq, fiq;
  logic [4:0]  src;
  logic [13:0] A;
  logic [7:0]  dout;
  wire  [7:0]  D;
  logic [7:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  assign D = drv ? dout : 8'bzzzz_zzzz;

  intc dut (
    .clk (clk), .rst (rst), .src (src), .irq (irq), .fiq (fiq),
    .D (D), .A (A), .cs (cs), .re (re), .we (we)
  );

  always #10 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed %02h expected %02h", tag, obs, e);
    end
  endtask

  task automatic rchk(input string tag, input logic [3:0] a, input logic [7:0] ev);
    logic [7:0] v;
    exp_q.push_back(ev);
    A  = {10'b0, a};
    cs = 1'b1;
    re = 1'b1;
    #1 v = D;
    cs = 1'b0;
    re = 1'b0;
    #1;
    chk(tag, v);
  endtask

  task automatic bchk(input string tag, input logic obs, input logic ev);
    exp_q.push_back({7'b0, ev});
    chk(tag, {7'b0, obs});
  endtask

  task automatic wr_start(input logic [3:0] a, input logic [7:0] d);
    A    = {10'b0, a};
    dout = d;
    drv  = 1'b1;
    cs   = 1'b1;
    we   = 1'b1;
  endtask

  task automatic wr_end();
    cs  = 1'b0;
    we  = 1'b0;
    drv = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_start(a, d);
    tick();
    wr_end();
    tick();
  endtask

  initial begin
    rst = 1'b1; src = '0; cs = 1'b0; re = 1'b0; we = 1'b0;
    A = '0; drv = 1'b0; dout = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    rchk("rst_raw", 4'h0, 8'h00);
    rchk("rst_pend", 4'h1, 8'h00);
    rchk("rst_en", 4'h2, 8'h1F);
    rchk("rst_mode", 4'h3, 8'h00);
    rchk("rst_route", 4'h4, 8'h10);
    rchk("rst_vec", 4'h5, 8'h00);
    rchk("rst_sum", 4'h6, 8'h00);
    rchk("rst_swset", 4'h7, 8'h00);
    rchk("rst_hi_addr", 4'hC, 8'h00);
    bchk("rst_irq", irq, 1'b0);
    bchk("rst_fiq", fiq, 1'b0);
    tick();

    // level mode: 3-clock latency both ways
    src = 5'b00010;
    tick(); tick();
    bchk("lvl_irq_early", irq, 1'b0);
    tick();
    bchk("lvl_irq_on", irq, 1'b1);
    rchk("lvl_vec", 4'h5, 8'h81);
    rchk("lvl_pend", 4'h1, 8'h02);
    src = 5'b00000;
    tick(); tick();
    bchk("lvl_irq_hold", irq, 1'b1);
    tick();
    bchk("lvl_irq_off", irq, 1'b0);

    // edge mode: 4-clock latency, sticky until W1C
    wr(4'h3, 8'h04);
    src = 5'b00100;
    tick(); tick();
    src = 5'b00000;
    tick();
    bchk("edge_irq_early", irq, 1'b0);
    rchk("edge_pend", 4'h1, 8'h04);
    tick();
    bchk("edge_irq_on", irq, 1'b1);
    repeat (3) tick();
    bchk("edge_irq_sticky", irq, 1'b1);
    rchk("edge_pend_sticky", 4'h1, 8'h04);
    wr_start(4'h1, 8'h04);
    tick();
    wr_end();
    bchk("w1c_lag", irq, 1'b1);
    rchk("w1c_pend", 4'h1, 8'h00);
    tick();
    bchk("w1c_irq", irq, 1'b0);

    // rising edge and W1C land on the same clock
    tick();
    src = 5'b00100;
    tick(); tick();
    wr_start(4'h1, 8'h04);
    tick();
    wr_end();
    src = 5'b00000;
    rchk("set_wins", 4'h1, 8'h04);
    tick();
    wr(4'h1, 8'h04);
    rchk("clr_after_sim", 4'h1, 8'h00);

    // routing and priority
    src = 5'b10000;
    repeat (3) tick();
    bchk("route_fiq", fiq, 1'b1);
    bchk("route_irq", irq, 1'b0);
    rchk("route_sum", 4'h6, 8'h02);
    src = 5'b00000;
    repeat (3) tick();
    bchk("route_fiq_off", fiq, 1'b0);
    src = 5'b01001;
    repeat (3) tick();
    bchk("prio_irq", irq, 1'b1);
    rchk("prio_vec", 4'h5, 8'h80);
    rchk("prio_pend", 4'h1, 8'h09);

    wr_start(4'h2, 8'h00);
    tick();
    wr_end();
    tick();
    bchk("dis_irq", irq, 1'b0);
    rchk("dis_pend", 4'h1, 8'h09);
    rchk("dis_vec", 4'h5, 8'h00);

    // long strobe with data changing: only the first edge commits
    wr_start(4'h2, 8'h01);
    tick();
    dout = 8'h1F;
    repeat (4) tick();
    wr_end();
    tick();
    rchk("strobe_once", 4'h2, 8'h01);
    bchk("reen_irq", irq, 1'b1);
    rchk("reen_vec", 4'h5, 8'h80);

    wr(4'h0, 8'hFF);
    wr(4'hC, 8'hFF);
    rchk("ro_raw", 4'h0, 8'h09);
    rchk("ro_en", 4'h2, 8'h01);

    // mid-operation reset with sources held high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bchk("mrst_irq", irq, 1'b0);
    rchk("mrst_en", 4'h2, 8'h1F);
    rchk("mrst_raw", 4'h0, 8'h00);
    repeat (3) tick();
    bchk("mrst_src_high", irq, 1'b1);
    src = 5'b00000;
    repeat (3) tick();
    bchk("mrst_quiet", irq, 1'b0);

`ifdef INTC_SWTRIG_EN
    wr(4'h7, 8'h08);
    bchk("sw_irq", irq, 1'b1);
    rchk("sw_pend", 4'h1, 8'h08);
    rchk("sw_read0", 4'h7, 8'h00);
    wr(4'h1, 8'h08);
    bchk("sw_w1c_irq", irq, 1'b0);
    rchk("sw_w1c_pend", 4'h1, 8'h00);
`else
    wr(4'h7, 8'h08);
    bchk("sw_off_irq", irq, 1'b0);
    rchk("sw_off_pend", 4'h1, 8'h00);
    rchk("sw_off_read", 4'h7, 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
